// File: rtl/lsu_pkg.sv
// Shared types and constants for the 64-bit load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_t;

  localparam logic [7:0] MASK_BYTE  = 8'h01;
  localparam logic [7:0] MASK_HALF  = 8'h03;
  localparam logic [7:0] MASK_WORD  = 8'h0F;
  localparam logic [7:0] MASK_DWORD = 8'hFF;

  function automatic logic [7:0] size_mask(input mem_size_t size);
    case (size)
      BYTE:    return MASK_BYTE;
      HALF:    return MASK_HALF;
      WORD:    return MASK_WORD;
      default: return MASK_DWORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, store-data shift, alignment
// check and load-data extraction for one access within a 64-bit word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [2:0]  lane_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic        misaligned_o,
  output logic [63:0] ldata_o
);

  mem_size_t   size;
  logic [5:0]  shamt;
  logic [63:0] rdata_sh;

  assign size     = mem_size_t'(size_i);
  assign shamt    = {lane_i, 3'b000};
  assign be_o     = size_mask(size) << lane_i;
  assign wdata_o  = wdata_i << shamt;
  assign rdata_sh = rdata_i >> shamt;

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    misaligned_o = 1'b0;
    ldata_o      = rdata_sh;
    case (size)
      BYTE: begin
        ldata_o = unsigned_i ? {56'b0, rdata_sh[7:0]}
                             : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
      end
      HALF: begin
        misaligned_o = lane_i[0];
        ldata_o = unsigned_i ? {48'b0, rdata_sh[15:0]}
                             : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      end
      WORD: begin
        misaligned_o = |lane_i[1:0];
        ldata_o = unsigned_i ? {32'b0, rdata_sh[31:0]}
                             : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      end
      default: begin
        misaligned_o = |lane_i;
        ldata_o      = rdata_sh;
      end
    endcase
  end

endmodule

// File: rtl/lsu_64bit.sv
// Load/store unit: accepts one access from execute, drives a 64-bit memory
// port with timeout, and returns extended load data or a fault/misaligned flag.
module lsu_64bit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, unsigned_q;
  logic [1:0]       size_q;
  logic [63:0]      addr_q, wdata_q;
  logic [63:0]      rdata_q, rdata_d;
  logic             mis_q, mis_d;
  logic             fault_q, fault_d;
  logic             accept;
  logic             in_idle, in_access;

  logic [1:0]       al_size;
  logic             al_unsigned;
  logic [2:0]       al_lane;
  logic [63:0]      al_wdata;
  logic [7:0]       al_be;
  logic [63:0]      al_wdata_sh;
  logic             al_misaligned;
  logic [63:0]      al_ldata;

  assign in_idle   = (state_q == IDLE);
  assign in_access = (state_q == ACCESS);

  // The aligner sees the live request in IDLE (for the alignment check at
  // accept) and the registered request afterwards, so memory outputs stay stable.
  assign al_size     = in_idle ? req_size        : size_q;
  assign al_unsigned = in_idle ? req_unsigned    : unsigned_q;
  assign al_lane     = in_idle ? req_addr[2:0]   : addr_q[2:0];
  assign al_wdata    = in_idle ? req_wdata       : wdata_q;

  lsu_lane_align u_align (
    .size_i       (al_size),
    .unsigned_i   (al_unsigned),
    .lane_i       (al_lane),
    .wdata_i      (al_wdata),
    .rdata_i      (mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata_sh),
    .misaligned_o (al_misaligned),
    .ldata_o      (al_ldata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    fault_d = fault_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          rdata_d = '0;
          fault_d = 1'b0;
          mis_d   = al_misaligned;
          state_d = al_misaligned ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        // An ack on the final wait cycle still completes normally.
        if (mem_ack) begin
          state_d = RESP;
          rdata_d = we_q ? 64'b0 : al_ldata;
          fault_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RESP;
          rdata_d = '0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
        rdata_d = '0;
        mis_d   = 1'b0;
        fault_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rdata_d = '0;
        mis_d   = 1'b0;
        fault_d = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: request registers are reset too; outputs are gated by state, but a
  // defined value keeps simulation X-free after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      we_q       <= req_we;
      unsigned_q <= req_unsigned;
      size_q     <= req_size;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
    end
  end

  assign req_ready       = in_idle;
  assign resp_valid      = (state_q == RESP);
  assign resp_rdata      = rdata_q;
  assign resp_misaligned = mis_q;
  assign resp_fault      = fault_q;

  assign mem_req   = in_access;
  assign mem_we    = in_access & we_q;
  assign mem_addr  = in_access ? {addr_q[63:3], 3'b000} : 64'b0;
  assign mem_be    = in_access ? al_be                  : 8'b0;
  assign mem_wdata = in_access ? al_wdata_sh            : 64'b0;

endmodule

// File: tb/tb_lsu_64bit.sv
// Directed self-checking bench for lsu_64bit built with a short timeout.
module tb_lsu_64bit;
  timeunit 1ns;
  timeprecision 1ps;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  lsu_64bit #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_fault      (resp_fault),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    #1;
    check("ready_before_accept", {63'b0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata,
                           input int waits, input logic [63:0] exp_addr,
                           input logic [7:0] exp_be, input logic [63:0] exp_wdata,
                           input logic [63:0] exp_rdata);
    issue(we, size, uns, addr, wdata);
    for (int i = 0; i < waits; i++) begin
      #1;
      check({tag, "_wait_req"},   {63'b0, mem_req},    64'd1);
      check({tag, "_wait_resp"},  {63'b0, resp_valid}, 64'd0);
      @(negedge clk);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1;
    check({tag, "_mem_req"},   {63'b0, mem_req},    64'd1);
    check({tag, "_mem_we"},    {63'b0, mem_we},     {63'b0, we});
    check({tag, "_mem_addr"},  mem_addr,            exp_addr);
    check({tag, "_mem_be"},    {56'b0, mem_be},     {56'b0, exp_be});
    check({tag, "_mem_wdata"}, mem_wdata,           exp_wdata);
    check({tag, "_early_rv"},  {63'b0, resp_valid}, 64'd0);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 64'h0;
    #1;
    check({tag, "_resp_valid"}, {63'b0, resp_valid},      64'd1);
    check({tag, "_resp_rdata"}, resp_rdata,               exp_rdata);
    check({tag, "_resp_mis"},   {63'b0, resp_misaligned}, 64'd0);
    check({tag, "_resp_fault"}, {63'b0, resp_fault},      64'd0);
    check({tag, "_resp_ready"}, {63'b0, req_ready},       64'd0);
    check({tag, "_resp_memreq"},{63'b0, mem_req},         64'd0);
    @(negedge clk);
    #1;
    check({tag, "_after_rv"},    {63'b0, resp_valid}, 64'd0);
    check({tag, "_after_rdata"}, resp_rdata,          64'd0);
    check({tag, "_after_ready"}, {63'b0, req_ready},  64'd1);
  endtask

  task automatic do_misaligned(input string tag, input logic [1:0] size, input logic [63:0] addr);
    issue(1'b0, size, 1'b0, addr, 64'h0);
    #1;
    check({tag, "_resp_valid"}, {63'b0, resp_valid},      64'd1);
    check({tag, "_resp_mis"},   {63'b0, resp_misaligned}, 64'd1);
    check({tag, "_resp_fault"}, {63'b0, resp_fault},      64'd0);
    check({tag, "_resp_rdata"}, resp_rdata,               64'd0);
    check({tag, "_mem_req"},    {63'b0, mem_req},         64'd0);
    @(negedge clk);
    #1;
    check({tag, "_after_rv"},  {63'b0, resp_valid},      64'd0);
    check({tag, "_after_mis"}, {63'b0, resp_misaligned}, 64'd0);
    check({tag, "_after_req"}, {63'b0, mem_req},         64'd0);
    check({tag, "_after_rdy"}, {63'b0, req_ready},       64'd1);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 64'h0;
    req_wdata    = 64'h0;
    mem_ack      = 1'b0;
    mem_rdata    = 64'h0;

    #1;
    check("rst_ready",  {63'b0, req_ready},  64'd1);
    check("rst_memreq", {63'b0, mem_req},    64'd0);
    check("rst_rv",     {63'b0, resp_valid}, 64'd0);
    check("rst_rdata",  resp_rdata,          64'd0);
    check("rst_be",     {56'b0, mem_be},     64'd0);
    check("rst_addr",   mem_addr,            64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // LB sign-extend, lane 3
    do_access("lb", 1'b0, 2'b00, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0,
              64'h1000, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
    // LWU zero-extend, upper word
    do_access("lwu", 1'b0, 2'b10, 1'b1, 64'h2004, 64'h0, 64'hDEAD_BEEF_1234_5678, 0,
              64'h2000, 8'hF0, 64'h0, 64'h0000_0000_DEAD_BEEF);
    // LW sign-extend with one wait cycle
    do_access("lw_wait", 1'b0, 2'b10, 1'b0, 64'h2004, 64'h0, 64'hDEAD_BEEF_1234_5678, 1,
              64'h2000, 8'hF0, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF);
    // LH sign-extend, lane 2
    do_access("lh", 1'b0, 2'b01, 1'b0, 64'h7002, 64'h0, 64'h0000_0000_8765_0000, 0,
              64'h7000, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_8765);
    // SH lane shift; read data must be ignored
    do_access("sh", 1'b1, 2'b01, 1'b0, 64'h3006, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 0,
              64'h3000, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0);
    // SD full word
    do_access("sd", 1'b1, 2'b11, 1'b0, 64'h8008, 64'h1122_3344_5566_7788, 64'h0, 2,
              64'h8008, 8'hFF, 64'h1122_3344_5566_7788, 64'h0);

    do_misaligned("mis_ld", 2'b11, 64'h4004);
    do_misaligned("mis_lh", 2'b01, 64'h5001);
    do_misaligned("mis_lw", 2'b10, 64'h5002);

    // Ack on the last permitted wait cycle completes normally
    do_access("ack_last", 1'b0, 2'b11, 1'b0, 64'h6000, 64'h0, 64'h0123_4567_89AB_CDEF, 4,
              64'h6000, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF);

    // Timeout: mem_req high for 5 cycles, then fault
    issue(1'b0, 2'b11, 1'b0, 64'h9000, 64'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("to_mem_req", {63'b0, mem_req},    64'd1);
      check("to_rv_low",  {63'b0, resp_valid}, 64'd0);
      @(negedge clk);
    end
    #1;
    check("to_resp_valid", {63'b0, resp_valid},      64'd1);
    check("to_fault",      {63'b0, resp_fault},      64'd1);
    check("to_mis",        {63'b0, resp_misaligned}, 64'd0);
    check("to_rdata",      resp_rdata,               64'd0);
    check("to_memreq_off", {63'b0, mem_req},         64'd0);
    @(negedge clk);
    #1;
    check("to_fault_clr", {63'b0, resp_fault}, 64'd0);
    check("to_ready",     {63'b0, req_ready},  64'd1);

    // Reset mid-ACCESS drops mem_req immediately and suppresses the response
    @(negedge clk);
    issue(1'b0, 2'b11, 1'b0, 64'hA000, 64'h0);
    #1;
    check("rma_memreq_pre", {63'b0, mem_req}, 64'd1);
    rst = 1'b1;
    #1;
    check("rma_memreq", {63'b0, mem_req},    64'd0);
    check("rma_ready",  {63'b0, req_ready},  64'd1);
    check("rma_rv",     {63'b0, resp_valid}, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rma_no_resp",  {63'b0, resp_valid}, 64'd0);
      check("rma_idle_req", {63'b0, mem_req},    64'd0);
      @(negedge clk);
    end
    mem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
